// File: rtl/count_h_cfg.sv
// count_h_cfg: configurable 0..23 hours counter with 12h/24h seven-segment display and day carry.
module count_h_cfg #(
    parameter int RST_HOUR    = 0,
    parameter bit SEG_ACT_LOW = 1'b0,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic       adv_hr,
    input  logic       dec_hr,
    input  logic       ld,
    input  logic [4:0] ld_val,
    input  logic       mode_24,
    output logic [4:0] hr_bin,
    output logic [6:0] h1,
    output logic [6:0] h0,
    output logic       am_pm,
    output logic       cy
);
    logic       up;
    logic [4:0] hr;
    logic [4:0] hr12;
    logic [4:0] disp;
    logic [1:0] tens;
    logic [3:0] ones;
    logic       blank;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'b1111110;
            4'd1: seg7 = 7'b0110000;
            4'd2: seg7 = 7'b1101101;
            4'd3: seg7 = 7'b1111001;
            4'd4: seg7 = 7'b0110011;
            4'd5: seg7 = 7'b1011011;
            4'd6: seg7 = 7'b1011111;
            4'd7: seg7 = 7'b1110000;
            4'd8: seg7 = 7'b1111111;
            4'd9: seg7 = 7'b1111011;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    assign up = enb | adv_hr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hr <= 5'(RST_HOUR);
            cy <= 1'b0;
        end else begin
            cy <= enb & ~dec_hr & ~ld & (hr == 5'd23);
            if (ld) begin
                if (ld_val <= 5'd23) hr <= ld_val;
            end else if (up & ~dec_hr) begin
                hr <= (hr == 5'd23) ? 5'd0 : hr + 5'd1;
            end else if (dec_hr & ~up) begin
                hr <= (hr == 5'd0) ? 5'd23 : hr - 5'd1;
            end
        end
    end

    // 12h mode maps hour 0 and 12 to "12"
    always_comb begin
        hr12  = (hr >= 5'd12) ? hr - 5'd12 : hr;
        disp  = mode_24 ? hr : ((hr12 == 5'd0) ? 5'd12 : hr12);
        tens  = (disp >= 5'd20) ? 2'd2 : (disp >= 5'd10) ? 2'd1 : 2'd0;
        ones  = 4'(disp - ((tens == 2'd2) ? 5'd20 : (tens == 2'd1) ? 5'd10 : 5'd0));
        blank = BLANK_LZ && !mode_24 && (disp < 5'd10);
    end

    assign hr_bin = hr;
    assign h1     = (blank ? 7'b0000000 : seg7({2'b00, tens})) ^ {7{SEG_ACT_LOW}};
    assign h0     = seg7(ones) ^ {7{SEG_ACT_LOW}};
    assign am_pm  = ~mode_24 & (hr >= 5'd12);
endmodule

// File: tb/tb_count_h_cfg.sv
// tb_count_h_cfg: directed plan plus random stimulus on two configurations, checked against a wall-clock model.
module tb_count_h_cfg;
    logic       clk = 1'b0;
    logic       rst = 1'b0, enb = 1'b0, adv_hr = 1'b0, dec_hr = 1'b0, ld = 1'b0, mode_24 = 1'b0;
    logic [4:0] ld_val = 5'd0;
    logic [4:0] a_hr, b_hr;
    logic [6:0] a_h1, a_h0, b_h1, b_h0;
    logic       a_pm, b_pm, a_cy, b_cy;
    int checks = 0, errors = 0;
    int mh[2];
    bit mc[2];
    int cy_cnt;
    localparam logic [6:0] SEGS[10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    localparam int RH[2] = '{0, 12};

    count_h_cfg dut_a (.clk(clk), .rst(rst), .enb(enb), .adv_hr(adv_hr), .dec_hr(dec_hr), .ld(ld),
        .ld_val(ld_val), .mode_24(mode_24), .hr_bin(a_hr), .h1(a_h1), .h0(a_h0), .am_pm(a_pm), .cy(a_cy));
    count_h_cfg #(.RST_HOUR(12), .SEG_ACT_LOW(1'b1), .BLANK_LZ(1'b1)) dut_b (.clk(clk), .rst(rst),
        .enb(enb), .adv_hr(adv_hr), .dec_hr(dec_hr), .ld(ld), .ld_val(ld_val), .mode_24(mode_24),
        .hr_bin(b_hr), .h1(b_h1), .h0(b_h0), .am_pm(b_pm), .cy(b_cy));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %b exp %b", tag, got, exp);
        end
    endtask

    // Expected {am_pm, h1, h0} for a wall-clock hour
    function automatic logic [14:0] show(input int h, input bit m24, input bit inv);
        int d;
        logic [6:0] t, o;
        d = m24 ? h : ((h % 12 == 0) ? 12 : h % 12);
        t = (!m24 && d < 10) ? 7'b0000000 : SEGS[d / 10];
        o = SEGS[d % 10];
        if (inv) begin
            t = ~t;
            o = ~o;
        end
        return {!m24 && h >= 12, t, o};
    endfunction

    task automatic check_all();
        logic [14:0] ea, eb;
        ea = show(mh[0], mode_24, 1'b0);
        eb = show(mh[1], mode_24, 1'b1);
        chk("a_hr", {2'b0, a_hr}, 7'(mh[0]));
        chk("a_h1", a_h1, ea[13:7]);
        chk("a_h0", a_h0, ea[6:0]);
        chk("a_pm", {6'b0, a_pm}, {6'b0, ea[14]});
        chk("a_cy", {6'b0, a_cy}, {6'b0, mc[0]});
        chk("b_hr", {2'b0, b_hr}, 7'(mh[1]));
        chk("b_h1", b_h1, eb[13:7]);
        chk("b_h0", b_h0, eb[6:0]);
        chk("b_pm", {6'b0, b_pm}, {6'b0, eb[14]});
        chk("b_cy", {6'b0, b_cy}, {6'b0, mc[1]});
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                mh[k] = RH[k];
                mc[k] = 1'b0;
            end else begin
                mc[k] = enb && !dec_hr && !ld && mh[k] == 23;
                if (ld) begin
                    if (ld_val <= 23) mh[k] = ld_val;
                end else if ((enb || adv_hr) && !dec_hr) mh[k] = (mh[k] + 1) % 24;
                else if (dec_hr && !(enb || adv_hr)) mh[k] = (mh[k] + 23) % 24;
            end
        end
        #1;
        check_all();
    endtask

    task automatic step(input bit r, input bit e, input bit a, input bit d, input bit l, input logic [4:0] v);
        rst = r; enb = e; adv_hr = a; dec_hr = d; ld = l; ld_val = v;
        tick();
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 0);
        chk("rst_h1", a_h1, 7'b0110000);
        chk("rst_h0", a_h0, 7'b1101101);
        chk("rst_b_h1", b_h1, 7'b1001111);
        chk("rst_b_pm", {6'b0, b_pm}, 7'd1);
        // full day in 12h mode
        cy_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            step(1, 1, 0, 0, 0, 0);
            cy_cnt += int'(a_cy);
        end
        chk("day_cy_cnt", 7'(cy_cnt), 7'd1);
        chk("day_hr", {2'b0, a_hr}, 7'd0);
        // adv_hr wrap gives no carry, enb wrap does
        step(1, 0, 0, 0, 1, 23);
        step(1, 0, 1, 0, 0, 0);
        chk("adv_wrap_cy", {6'b0, a_cy}, 7'd0);
        step(1, 0, 0, 0, 1, 23);
        step(1, 1, 0, 0, 0, 0);
        chk("enb_wrap_cy", {6'b0, a_cy}, 7'd1);
        step(1, 0, 0, 0, 0, 0);
        // decrement wrap in 24h mode
        mode_24 = 1'b1;
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0, 0);
        chk("dec_h0_3", a_h0, 7'b1111001);
        step(1, 0, 0, 1, 0, 0);
        chk("dec_hr_22", {2'b0, a_hr}, 7'd22);
        // conflicts and invalid load
        step(1, 0, 0, 0, 1, 5);
        step(1, 1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1, 30);
        chk("ld_bad", {2'b0, a_hr}, 7'd5);
        step(1, 1, 0, 0, 1, 9);
        // display modes
        step(1, 0, 0, 0, 1, 7);
        chk("h7_24_h1", a_h1, 7'b1111110);
        mode_24 = 1'b0;
        #1 check_all();
        chk("h7_12_blank", a_h1, 7'b0000000);
        step(1, 0, 0, 0, 1, 13);
        chk("h13_pm", {6'b0, a_pm}, 7'd1);
        // reset beats load and enable
        step(0, 1, 0, 0, 1, 15);
        chk("rst_pri", {2'b0, a_hr}, 7'd0);
        chk("rst_pri_b", {2'b0, b_hr}, 7'd12);
        // random
        for (int i = 0; i < 600; i++) begin
            if (i % 37 == 0) mode_24 = 1'($urandom);
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0), 5'($urandom));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/count_h_cfg.md
Name: count_h_cfg

Overview:
Configurable hours counter for the digital-clock datapath: a parametrised successor to the fixed 12-hour counter. Holds hour internally as 0..23 and advances on the minutes carry (enb) or the set button (adv_hr). Adds decrement, direct load, a runtime-selectable 12h/24h display, a day-carry output and configurable seven-segment polarity and blanking. Drives the two hour digits and the AM/PM indicator; its cy feeds a future day/date counter.

Parameters:
RST_HOUR, 0, internal hour (0..23) loaded on reset; 0 = midnight (shows 12 AM in 12h mode).
SEG_ACT_LOW, 0, 1 = invert h1/h0 segment outputs for common-anode displays.
BLANK_LZ, 1, 1 = blank the tens digit in 12h mode when the displayed hour is 1..9.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-low reset (asserted when 0)
enb  in  1  count enable / minutes carry; advances one hour per cycle when high
adv_hr  in  1  set-button advance; advances one hour per cycle when high
dec_hr  in  1  set-button decrement; retreats one hour per cycle when high
ld  in  1  load strobe
ld_val  in  5  hour to load, binary 0..23
mode_24  in  1  0 = 12h display, 1 = 24h display
hr_bin  out  5  internal hour register, binary 0..23
h1  out  7  tens-digit segments {a,b,c,d,e,f,g}, bit 6 = a
h0  out  7  ones-digit segments, same ordering
am_pm  out  1  1 = PM
cy  out  1  one-cycle day-carry pulse

Behaviour:
- Only state: 5-bit hour register hr, plus registered cy. hr_bin = hr. All other outputs are combinational from hr and mode_24.
- Reset (rst == 0 at a rising edge): hr <= RST_HOUR and cy <= 0. Reset has priority over every other input, including during a load or advance.
- Priority when rst == 1: ld, then advance/decrement.
- ld == 1 with ld_val <= 23: hr <= ld_val and cy <= 0.
- ld == 1 with ld_val > 23: hr unchanged and cy <= 0; the load is ignored.
- Advance request up = enb | adv_hr. enb and adv_hr together advance by exactly one.
- up & !dec_hr: hr <= (hr == 23) ? 0 : hr + 1.
- dec_hr & !up: hr <= (hr == 0) ? 23 : hr - 1.
- up & dec_hr: hr unchanged.
- cy <= 1 only when enb == 1, dec_hr == 0, ld == 0 and hr == 23 at the edge. This is a 23 -> 0 wrap caused by enb, not by adv_hr alone.
- cy is 0 in every other cycle. A decrement wrap 0 -> 23 never pulses cy.
- Latency: outputs reflect the new hr one clock after the edge where the input is sampled. No other pipeline delay.
- 24h display: digits = hr / 10 and hr % 10. Tens digit always shown, including leading 0. am_pm = 0.
- 12h display: disp = (hr % 12 == 0) ? 12 : hr % 12, giving digits disp / 10 and disp % 10. am_pm = (hr >= 12).
- Blanking: if BLANK_LZ == 1 in 12h mode and disp < 10, h1 = blank (all segments off).
- mode_24 changes only the display. hr is unaffected and the display updates combinationally in the same cycle.
- Active-high segment codes (abcdefg):
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011
  - 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011
  - blank = 0000000
- SEG_ACT_LOW == 1 inverts all 14 segment bits, including blank, which becomes 1111111.
- Reset-state outputs with defaults: hr_bin = 0, 12h mode shows h1 = 0110000 and h0 = 1101101 ("12"), am_pm = 0, cy = 0.

Test Plan:
1. Reset, then release. Mode 12h, enb = 1 for 24 cycles. Required: display sequence 12,1..11 AM then 12,1..11 PM. am_pm rises when hr_bin = 12. Final hr_bin = 0 with a single cy pulse on the 23 -> 0 edge.
2. ld = 1 with ld_val = 23, then one cycle of adv_hr = 1 (enb = 0). Required: hr_bin = 0 and cy stays 0. Repeating the same sequence with enb = 1 instead gives cy = 1 for exactly one cycle.
3. hr = 0, dec_hr = 1 for 2 cycles. Required: hr_bin = 23 then 22, cy = 0 throughout. In 24h mode the display shows "23" then "22".
4. hr = 5: apply enb = 1 with dec_hr = 1 (hr_bin holds 5). Then ld = 1 with ld_val = 30 (hr_bin holds 5). Then ld = 1 together with enb = 1 and ld_val = 9 (hr_bin = 9).
5. hr = 7: toggle mode_24. Required: 24h shows h1 = 1111110 ("0"), h0 = 1110000. 12h with BLANK_LZ = 1 shows h1 = 0000000. hr = 13 in 12h mode shows "1" with am_pm = 1.
6. Assert rst = 0 in the same cycle as ld = 1 / ld_val = 15 and enb = 1. Required: hr_bin = RST_HOUR and cy = 0. Repeat with RST_HOUR = 12 and SEG_ACT_LOW = 1: outputs are "12" PM with all segment bits inverted.
